// File: rtl/regfile_32x32.sv
// 32 x WIDTH register file: one-hot write select, two registered read ports, a sticky
// multi-hot error flag and a saturating count of accepted writes. Optional REGFILE_BYPASS_EN.
module regfile_32x32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      w,
    input  logic [WIDTH-1:0] d,
    input  logic [4:0]       ra,
    input  logic [4:0]       rb,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic             err,
    output logic [CNT_W-1:0] wcnt
);

    logic [WIDTH-1:0] mem [32];
    logic             w_any;
    logic             w_onehot;
    logic             w_multi;
    logic [4:0]       w_idx;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // A non-zero value is one-hot exactly when clearing its lowest set bit leaves zero.
    assign w_any    = (w != 32'd0);
    assign w_onehot = w_any && ((w & (w - 32'd1)) == 32'd0);
    assign w_multi  = w_any && !w_onehot;

    always_comb begin
        w_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) begin
                w_idx = i[4:0];
            end
        end
    end

    always_comb begin
        rd_a = (ra == 5'd0) ? '0 : mem[ra];
        rd_b = (rb == 5'd0) ? '0 : mem[rb];
`ifdef REGFILE_BYPASS_EN
        // Write-through: a read of the register being written returns the incoming data.
        if (w_onehot && (w_idx != 5'd0) && (w_idx == ra)) begin
            rd_a = d;
        end
        if (w_onehot && (w_idx != 5'd0) && (w_idx == rb)) begin
            rd_b = d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
            qa   <= '0;
            qb   <= '0;
            err  <= 1'b0;
            wcnt <= '0;
        end else begin
            qa <= rd_a;
            qb <= rd_b;
            if (w_onehot && (w_idx != 5'd0)) begin
                mem[w_idx] <= d;
            end
            if (w_multi) begin
                err <= 1'b1;
            end
            if (w_onehot && (wcnt != {CNT_W{1'b1}})) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32; a second instance with CNT_W=4 covers counter saturation.
module tb_regfile_32x32;

    logic        clk;
    logic        rst;
    logic [31:0] w;
    logic [31:0] d;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        err;
    logic [15:0] wcnt;
    logic [31:0] qa4;
    logic [31:0] qb4;
    logic        err4;
    logic [3:0]  wcnt4;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_32x32 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .w(w), .d(d), .ra(ra), .rb(rb),
        .qa(qa), .qb(qb), .err(err), .wcnt(wcnt)
    );

    regfile_32x32 #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .w(w), .d(d), .ra(ra), .rb(rb),
        .qa(qa4), .qb(qb4), .err(err4), .wcnt(wcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        w   = 32'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        d  = 32'd0;
        ra = 5'd0;
        rb = 5'd0;
        do_reset();
        ra = 5'd5;
        rb = 5'd31;
        tick();
        n_cmp++; if (qa !== 32'd0) begin n_fail++; $display("FAIL reset_qa got %h want 0", qa); end
        n_cmp++; if (qb !== 32'd0) begin n_fail++; $display("FAIL reset_qb got %h want 0", qb); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (wcnt !== 16'd0) begin n_fail++; $display("FAIL reset_wcnt got %0d want 0", wcnt); end
    endtask

    task automatic test_write_read();
        do_reset();
        w = 32'h0000_0008; d = 32'hDEAD_BEEF; ra = 5'd0; rb = 5'd0;
        tick();
        w = 32'd0; ra = 5'd3;
        tick();
        n_cmp++; if (qa !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_r3_qa got %h want deadbeef", qa); end
        n_cmp++; if (wcnt !== 16'd1) begin n_fail++; $display("FAIL wr_r3_wcnt got %0d want 1", wcnt); end
    endtask

    task automatic test_r0();
        do_reset();
        w = 32'h0000_0001; d = 32'hFFFF_FFFF;
        tick();
        w = 32'd0; ra = 5'd0; rb = 5'd0;
        tick();
        n_cmp++; if (qa !== 32'd0) begin n_fail++; $display("FAIL r0_qa got %h want 0", qa); end
        n_cmp++; if (qb !== 32'd0) begin n_fail++; $display("FAIL r0_qb got %h want 0", qb); end
        n_cmp++; if (wcnt !== 16'd1) begin n_fail++; $display("FAIL r0_wcnt got %0d want 1", wcnt); end
    endtask

    task automatic test_multihot();
        do_reset();
        w = 32'h0000_0002; d = 32'h0000_0011; tick();
        w = 32'h0000_0004; d = 32'h0000_0022; tick();
        w = 32'h0000_0006; d = 32'h0000_1234; tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL multi_err got %b want 1", err); end
        n_cmp++; if (wcnt !== 16'd2) begin n_fail++; $display("FAIL multi_wcnt got %0d want 2", wcnt); end
        w = 32'd0; ra = 5'd1; rb = 5'd2;
        tick();
        tick();
        n_cmp++; if (qa !== 32'h11) begin n_fail++; $display("FAIL multi_r1 got %h want 11", qa); end
        n_cmp++; if (qb !== 32'h22) begin n_fail++; $display("FAIL multi_r2 got %h want 22", qb); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL multi_err_sticky got %b want 1", err); end
        n_cmp++; if (wcnt !== 16'd2) begin n_fail++; $display("FAIL multi_wcnt_hold got %0d want 2", wcnt); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL multi_err_clear got %b want 0", err); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        do_reset();
        exp = BYP ? 32'hA5A5_A5A5 : 32'd0;
        w = 32'h0000_0010; d = 32'hA5A5_A5A5; ra = 5'd4; rb = 5'd4;
        tick();
        w = 32'd0;
        n_cmp++; if (qa !== exp) begin n_fail++; $display("FAIL same_qa got %h want %h", qa, exp); end
        n_cmp++; if (qb !== exp) begin n_fail++; $display("FAIL same_qb got %h want %h", qb, exp); end
        tick();
        n_cmp++; if (qa !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL same_next_qa got %h want a5a5a5a5", qa); end
    endtask

    task automatic test_all_regs();
        logic [31:0] ea;
        logic [31:0] eb;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            w = 32'd1 << i;
            d = 32'h0101_0101 * i + 32'h0F00_0000;
            tick();
        end
        w = 32'd0;
        n_cmp++; if (wcnt !== 16'd32) begin n_fail++; $display("FAIL all_wcnt got %0d want 32", wcnt); end
        for (int i = 0; i < 32; i++) begin
            ra = i[4:0];
            rb = 5'd31 - i[4:0];
            tick();
            ea = (i == 0) ? 32'd0 : 32'h0101_0101 * i + 32'h0F00_0000;
            eb = (i == 31) ? 32'd0 : 32'h0101_0101 * (31 - i) + 32'h0F00_0000;
            n_cmp++; if (qa !== ea) begin n_fail++; $display("FAIL all_qa[%0d] got %h want %h", i, qa, ea); end
            n_cmp++; if (qb !== eb) begin n_fail++; $display("FAIL all_qb[%0d] got %h want %h", 31 - i, qb, eb); end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        w = 32'h0000_0008; d = 32'h0000_CAFE; tick();
        ra = 5'd3;
        rst = 1'b1; w = 32'h0000_0020; d = 32'h0000_BEEF;
        tick();
        rst = 1'b0; w = 32'd0;
        n_cmp++; if (qa !== 32'd0) begin n_fail++; $display("FAIL rstpri_qa got %h want 0", qa); end
        n_cmp++; if (wcnt !== 16'd0) begin n_fail++; $display("FAIL rstpri_wcnt got %0d want 0", wcnt); end
        ra = 5'd5; rb = 5'd3;
        tick();
        n_cmp++; if (qa !== 32'd0) begin n_fail++; $display("FAIL rstpri_r5 got %h want 0", qa); end
        n_cmp++; if (qb !== 32'd0) begin n_fail++; $display("FAIL rstpri_r3 got %h want 0", qb); end
    endtask

    task automatic test_saturation();
        do_reset();
        d = 32'h0000_0077;
        for (int i = 1; i <= 17; i++) begin
            w = 32'h0000_0002;
            tick();
            if (i == 15) begin
                n_cmp++; if (wcnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_at15 got %0d want 15", wcnt4); end
            end
        end
        w = 32'd0;
        n_cmp++; if (wcnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", wcnt4); end
        n_cmp++; if (wcnt !== 16'd17) begin n_fail++; $display("FAIL sat_wide got %0d want 17", wcnt); end
        do_reset();
        n_cmp++; if (wcnt4 !== 4'd0) begin n_fail++; $display("FAIL sat_reset got %0d want 0", wcnt4); end
    endtask

    initial begin
        rst = 1'b0; w = 32'd0; d = 32'd0; ra = 5'd0; rb = 5'd0;
        test_reset();
        test_write_read();
        test_r0();
        test_multihot();
        test_same_cycle();
        test_all_regs();
        test_reset_priority();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_32x32.md
REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width of each register and of the write/read data ports.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the accepted-write counter.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port w, input, 32: write-select, one-hot, driven by the 5-to-32 write-address decoder; all-zero means no write.
REQ-006 The block SHALL have port d, input, WIDTH: write data.
REQ-007 The block SHALL have port ra, input, 5: read address, port A.
REQ-008 The block SHALL have port rb, input, 5: read address, port B.
REQ-009 The block SHALL have port qa, output, WIDTH: registered read data, port A.
REQ-010 The block SHALL have port qb, output, WIDTH: registered read data, port B.
REQ-011 The block SHALL have port err, output, 1: sticky flag, set when w is multi-hot.
REQ-012 The block SHALL have port wcnt, output, CNT_W: count of accepted writes.

Function
REQ-013 The block SHALL hold 32 registers R0..R31 of WIDTH bits.
REQ-014 R0 SHALL read as zero at all times; a write selecting R0 SHALL be accepted but SHALL not change R0.
REQ-015 At each rising edge where w has exactly one bit k set, the block SHALL load d into Rk.
REQ-016 At each rising edge where w is all-zero, no register SHALL change.
REQ-017 At each rising edge where w has two or more bits set, no register SHALL change and err SHALL be set to 1.
REQ-018 Once set, err SHALL remain 1 until rst.
REQ-019 Read latency SHALL be one cycle: qa is R[ra] and qb is R[rb], both sampled at the rising edge, and update on the following cycle.
REQ-020 ra and rb SHALL be independent; ra equal to rb SHALL give identical qa and qb.
REQ-021 wcnt SHALL increment by 1 on every edge with a one-hot w, including writes to R0.
REQ-022 wcnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-023 Multi-hot or zero w SHALL not increment wcnt.
REQ-024 A simultaneous write and read of the same register Rk (k not 0) SHALL follow REQ-031/REQ-032.
REQ-025 Read data SHALL never be X after reset for any in-range address.

Reset
REQ-026 On a rising edge with rst=1, registers R1..R31 SHALL clear to 0.
REQ-027 On a rising edge with rst=1, qa and qb SHALL clear to 0.
REQ-028 On a rising edge with rst=1, err SHALL clear to 0 and wcnt SHALL clear to 0.
REQ-029 rst SHALL take priority over any write in the same cycle; that write SHALL be discarded and not counted.
REQ-030 Outputs SHALL be defined (0) from the first edge after rst asserts, including when rst arrives mid-sequence.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined, a read port whose address equals the one-hot written index k (k not 0) in the same cycle SHALL return d on the next cycle (write-through forwarding).
REQ-032 Without REGFILE_BYPASS_EN, such a read SHALL return the pre-write value of Rk; the new value SHALL appear on a read issued one cycle later.

Verification
REQ-033 rst=1 for one edge, then ra=5, rb=31 -> qa=0, qb=0, err=0, wcnt=0.
REQ-034 w=32'h0000_0008, d=32'hDEAD_BEEF, then ra=3 next cycle -> qa=32'hDEAD_BEEF one cycle after ra is applied, wcnt=1.
REQ-035 w=32'h0000_0001, d=32'hFFFF_FFFF, then ra=0 -> qa=0, wcnt=1.
REQ-036 w=32'h0000_0006, d=32'h1234 -> R1 and R2 unchanged, err=1 and stays 1 with subsequent w=0, wcnt unchanged.
REQ-037 Same-cycle w=32'h0000_0010, d=32'hA5A5_A5A5, ra=4, R4 previously 0 -> qa=32'hA5A5_A5A5 with REGFILE_BYPASS_EN, qa=0 without it.
REQ-038 CNT_W=4, 17 one-hot writes -> wcnt=15 after the 15th write and holds at 15; then rst -> wcnt=0.
